sdram_arbiter: RTL and testbench

- Two-port arbiter that shares the single SDRAM controller (32-bit word, 24-bit word address, start/q_ready handshake) between two requesters, e.g. CPU bus (port 0) and GPU/DMA fetch (port 1).
- Gates all traffic until SDRAM init completes and serialises transactions.
- Translates a simple req/ack protocol into the controller's hold-start-until-q_ready, drop-start-to-release protocol.

---
 rtl/sdram_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
//
// Shares one SDRAM controller between two requesters. Port 0 is typically
// the CPU bus and port 1 a GPU/DMA fetch path. The arbiter blocks all
// traffic until the controller finishes initialisation. It runs one
// transaction at a time. It converts the requesters' req/ack handshake
// into the controller's protocol: start is held until q_ready, and start
// is dropped to release the controller.
//
// Build option:
//   SDRAM_ARB_FIXED_PRIO_EN  when defined, port 0 always wins simultaneous
//                            requests. When undefined, simultaneous
//                            requests alternate round-robin.
//
// Parameters:
//   ADDR_W  word address width passed to the controller (default 24)
//   DATA_W  data width (default 32)
//
// Ports:
//   clk, resetn          clock (rising edge) and async active-low reset
//   pN_req               request, held high until pN_ack
//   pN_we                1 = write, 0 = read, stable while pN_req is high
//   pN_addr, pN_wdata    word address and write data
//   pN_ack               one-cycle completion pulse
//   pN_rdata             read data, valid with pN_ack; held until the next
//                        read on the same port completes
//   mem_start            controller start, held until mem_q_ready
//   mem_we/addr/d        command fields, latched at grant
//   mem_q, mem_q_ready   controller read data and completion strobe
//   mem_busy             controller not idle (this includes refresh)
//   mem_init_done        controller initialisation has finished
//   grant                one-hot owner of the current transaction;
//                        00 when no transaction is in progress
//
// All outputs are driven directly from flops.
// -----------------------------------------------------------------------------
//
// state        | meaning
// -------------+----------------------------------------------------------
// S_WAIT_INIT  | controller still initialising; requests are ignored
// S_IDLE       | waiting for a request while the controller is not busy
// S_ACTIVE     | mem_start held high; waiting for mem_q_ready
// S_RELEASE    | mem_start dropped; waiting for the controller to go idle
//
module sdram_arbiter #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,

  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,

  output logic              mem_start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_d,
  input  logic [DATA_W-1:0] mem_q,
  input  logic              mem_q_ready,
  input  logic              mem_busy,
  input  logic              mem_init_done,

  output logic [1:0]        grant
);

  typedef enum logic [1:0] {
    S_WAIT_INIT = 2'd0,
    S_IDLE      = 2'd1,
    S_ACTIVE    = 2'd2,
    S_RELEASE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                mem_start_q, mem_start_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_d_q, mem_d_d;
  logic                p0_ack_q, p0_ack_d;
  logic                p1_ack_q, p1_ack_d;
  logic [DATA_W-1:0]   p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0]   p1_rdata_q, p1_rdata_d;
  logic [1:0]          grant_q, grant_d;
  logic                pick_p1;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  // Port 1 wins only when port 0 is not asking.
  assign pick_p1 = p1_req & ~p0_req;
`else
  // last_port records which port finished most recently. It resets to 1,
  // so port 0 wins the first tie.
  logic last_port_q, last_port_d;

  assign pick_p1 = p1_req & (~p0_req | ~last_port_q);
`endif

  always_comb begin
    state_d     = state_q;
    mem_start_d = mem_start_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_d_d     = mem_d_q;
    p0_ack_d    = 1'b0;
    p1_ack_d    = 1'b0;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    grant_d     = grant_q;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
    last_port_d = last_port_q;
`endif

    case (state_q)
      S_WAIT_INIT: begin
        if (mem_init_done) begin
          state_d = S_IDLE;
        end
      end

      S_IDLE: begin
        if (!mem_busy && (p0_req || p1_req)) begin
          mem_we_d    = pick_p1 ? p1_we    : p0_we;
          mem_addr_d  = pick_p1 ? p1_addr  : p0_addr;
          mem_d_d     = pick_p1 ? p1_wdata : p0_wdata;
          grant_d     = pick_p1 ? 2'b10    : 2'b01;
          mem_start_d = 1'b1;
          state_d     = S_ACTIVE;
        end
      end

      S_ACTIVE: begin
        // A refresh only delays mem_q_ready, so no timeout is needed here.
        if (mem_q_ready) begin
          if (grant_q[1]) begin
            p1_ack_d = 1'b1;
            if (!mem_we_q) begin
              p1_rdata_d = mem_q;
            end
          end else begin
            p0_ack_d = 1'b1;
            if (!mem_we_q) begin
              p0_rdata_d = mem_q;
            end
          end
`ifndef SDRAM_ARB_FIXED_PRIO_EN
          last_port_d = grant_q[1];
`endif
          mem_start_d = 1'b0;
          grant_d     = 2'b00;
          state_d     = S_RELEASE;
        end
      end

      S_RELEASE: begin
        if (!mem_busy) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_WAIT_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_WAIT_INIT;
      mem_start_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_d_q     <= '0;
      p0_ack_q    <= 1'b0;
      p1_ack_q    <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
      grant_q     <= 2'b00;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
      last_port_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      mem_start_q <= mem_start_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_d_q     <= mem_d_d;
      p0_ack_q    <= p0_ack_d;
      p1_ack_q    <= p1_ack_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
      grant_q     <= grant_d;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
      last_port_q <= last_port_d;
`endif
    end
  end

  assign mem_start = mem_start_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_d     = mem_d_q;
  assign p0_ack    = p0_ack_q;
  assign p1_ack    = p1_ack_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter. The bench plays the SDRAM controller by
// hand. It drives inputs and samples outputs on the falling clock edge.
module tb_sdram_arbiter;

  logic        clk;
  logic        resetn;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [23:0] p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic        p0_ack, p1_ack;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_start, mem_we;
  logic [23:0] mem_addr;
  logic [31:0] mem_d, mem_q;
  logic        mem_q_ready, mem_busy, mem_init_done;
  logic [1:0]  grant;

  int total = 0;
  int bad   = 0;

  sdram_arbiter #(.ADDR_W(24), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .mem_start(mem_start), .mem_we(mem_we), .mem_addr(mem_addr), .mem_d(mem_d),
    .mem_q(mem_q), .mem_q_ready(mem_q_ready), .mem_busy(mem_busy),
    .mem_init_done(mem_init_done), .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait, with a cycle limit, until the arbiter raises mem_start.
  task automatic wait_start(input string tag);
    int n = 0;
    while (mem_start !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    check(tag, {63'd0, mem_start}, 64'd1);
  endtask

  // Plays the controller for one transaction that is already in S_ACTIVE.
  // It stays busy for lat cycles, then returns q with q_ready. The task
  // returns on the falling edge where the ack is visible.
  task automatic serve(input logic [31:0] q, input int lat, output logic [1:0] ack_seen);
    mem_busy = 1'b1;
    repeat (lat) tick();
    check("start_hold", {63'd0, mem_start}, 64'd1);
    mem_q = q;
    mem_q_ready = 1'b1;
    tick();
    ack_seen = {p1_ack, p0_ack};
    mem_q_ready = 1'b0;
    mem_q = 32'd0;
    mem_busy = 1'b0;
  endtask

  initial begin
    logic [1:0] acks;
    logic [1:0] exp_g;
    int cnt;

    resetn = 1'b0;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    mem_q = 0; mem_q_ready = 0; mem_busy = 0; mem_init_done = 0;

    // Reset state
    repeat (3) tick();
    check("rst_start", {63'd0, mem_start}, 64'd0);
    check("rst_grant", {62'd0, grant}, 64'd0);
    check("rst_ack", {62'd0, p1_ack, p0_ack}, 64'd0);
    check("rst_rdata", {p1_rdata, p0_rdata}, 64'd0);
    check("rst_fields", {7'd0, mem_we, mem_addr, mem_d}, 64'd0);
    resetn = 1'b1;

    // Init gating: a pending request must not be issued before init_done
    p0_req = 1; p0_we = 0; p0_addr = 24'h000123;
    cnt = 0;
    repeat (50) begin
      tick();
      if (mem_start === 1'b1 || p0_ack === 1'b1) cnt++;
    end
    check("init_gate", cnt, 0);
    mem_init_done = 1;
    tick();
    check("init_t1", {63'd0, mem_start}, 64'd0);
    tick();
    check("init_t2", {63'd0, mem_start}, 64'd1);

    // Single read
    check("rd_addr", {40'd0, mem_addr}, 64'h000123);
    check("rd_we", {63'd0, mem_we}, 64'd0);
    check("rd_grant", {62'd0, grant}, 64'd1);
    serve(32'hDEADBEEF, 3, acks);
    check("rd_ack", {62'd0, acks}, 64'd1);
    check("rd_data", {32'd0, p0_rdata}, 64'hDEADBEEF);
    check("rd_grant_clr", {62'd0, grant}, 64'd0);
    check("rd_start_clr", {63'd0, mem_start}, 64'd0);
    p0_req = 0;
    tick();
    check("rd_ack_1cyc", {63'd0, p0_ack}, 64'd0);
    tick();

    // Write then read back on port 1. Fields are latched at grant.
    p1_req = 1; p1_we = 1; p1_addr = 24'h7FFFFF; p1_wdata = 32'hCAFEF00D;
    wait_start("wr_start");
    p1_wdata = 32'h12345678;
    p1_addr = 24'h000001;
    tick();
    check("wr_we", {63'd0, mem_we}, 64'd1);
    check("wr_addr", {40'd0, mem_addr}, 64'h7FFFFF);
    check("wr_d", {32'd0, mem_d}, 64'hCAFEF00D);
    check("wr_grant", {62'd0, grant}, 64'd2);
    serve(32'h11111111, 2, acks);
    check("wr_ack", {62'd0, acks}, 64'd2);
    check("wr_rdata_keep", {32'd0, p1_rdata}, 64'd0);
    p1_we = 0; p1_addr = 24'h7FFFFF;
    wait_start("rb_start");
    check("rb_we", {63'd0, mem_we}, 64'd0);
    check("rb_addr", {40'd0, mem_addr}, 64'h7FFFFF);
    serve(32'hCAFEF00D, 2, acks);
    check("rb_ack", {62'd0, acks}, 64'd2);
    check("rb_data", {32'd0, p1_rdata}, 64'hCAFEF00D);
    check("rb_p0_keep", {32'd0, p0_rdata}, 64'hDEADBEEF);
    p1_req = 0;

    // Contention: both ports hold req for six transactions
    p0_req = 1; p0_we = 0; p1_we = 0;
    p1_req = 1;
    for (int i = 0; i < 6; i++) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
      exp_g = 2'b01;
`else
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
      wait_start("ct_start");
      check("ct_grant", {62'd0, grant}, {62'd0, exp_g});
      serve(32'hA000_0000 + i, 1, acks);
      check("ct_ack", {62'd0, acks}, {62'd0, exp_g});
      if (exp_g == 2'b01) check("ct_rdata0", {32'd0, p0_rdata}, 64'hA000_0000 + i);
      else                check("ct_rdata1", {32'd0, p1_rdata}, 64'hA000_0000 + i);
    end
    p0_req = 0; p1_req = 0;
    repeat (3) tick();

    // A stray q_ready outside S_ACTIVE must not cause an ack
    mem_q_ready = 1; mem_q = 32'hBAD0BAD0;
    tick();
    mem_q_ready = 0; mem_q = 0;
    tick();
    check("stray_ack", {62'd0, p1_ack, p0_ack}, 64'd0);
    check("stray_rdata", {32'd0, p0_rdata}, 64'hA000_0004);

    // Busy gating followed by a refresh during S_ACTIVE
    mem_busy = 1;
    p0_req = 1; p0_addr = 24'h000055;
    cnt = 0;
    repeat (20) begin
      tick();
      if (mem_start === 1'b1) cnt++;
    end
    check("busy_gate", cnt, 0);
    mem_busy = 0;
    tick();
    check("busy_release", {63'd0, mem_start}, 64'd1);
    mem_busy = 1;
    cnt = 0;
    repeat (10) begin
      tick();
      if (mem_start !== 1'b1 || p0_ack === 1'b1) cnt++;
    end
    check("refresh_hold", cnt, 0);
    serve(32'h55555555, 0, acks);
    check("refresh_ack", {62'd0, acks}, 64'd1);
    p0_req = 0;
    cnt = 0;
    repeat (5) begin
      tick();
      if (p0_ack === 1'b1) cnt++;
    end
    check("refresh_single", cnt, 0);

    // Reset in the middle of a transaction
    p0_req = 1; p0_addr = 24'h000077;
    wait_start("rm_start");
    mem_busy = 1;
    repeat (2) tick();
    mem_q_ready = 1;
    resetn = 0;
    #1;
    check("rm_start_clr", {63'd0, mem_start}, 64'd0);
    check("rm_grant_clr", {62'd0, grant}, 64'd0);
    tick();
    check("rm_no_ack", {62'd0, p1_ack, p0_ack}, 64'd0);
    check("rm_rdata_clr", {32'd0, p0_rdata}, 64'd0);
    mem_q_ready = 0;
    resetn = 1;
    cnt = 0;
    repeat (10) begin
      tick();
      if (mem_start === 1'b1) cnt++;
    end
    check("rm_busy_gate", cnt, 0);
    mem_busy = 0;
    tick();
    check("rm_restart", {63'd0, mem_start}, 64'd1);
    serve(32'h77777777, 1, acks);
    check("rm_final_ack", {62'd0, acks}, 64'd1);
    check("rm_final_data", {32'd0, p0_rdata}, 64'h77777777);
    p0_req = 0;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
